// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one W+1-bit trial subtract per cycle,
// start/done handshake, quotient and remainder held until the next result.
module seq_divider #(
   parameter int unsigned W = 8
) (
   input  logic         C,
   input  logic         RN,
   input  logic         START,
   input  logic [W-1:0] DIVIDEND,
   input  logic [W-1:0] DIVISOR,
   output logic         BUSY,
   output logic         DONE,
   output logic [W-1:0] QUO,
   output logic [W-1:0] REM,
   output logic         DZ
);

   localparam int unsigned CW = $clog2(W + 1);

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e state_q, state_d;

   // Dividend bits leave at the top while quotient bits enter at the bottom,
   // so one register serves as both D and Q; after W steps it holds Q.
   logic [W-1:0]  dq_q, dq_d;
   logic [W-1:0]  v_q, v_d;
   logic [W-1:0]  p_q, p_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [W-1:0]  rem_q, rem_d;
   logic          dz_q, dz_d;

   logic [W:0]    shifted;
   logic [W:0]    trial;
   logic          q_bit;

   always_comb begin
      shifted = {1'b0, p_q, dq_q[W-1]} >> 0;
      shifted = {p_q, dq_q[W-1]};
      trial   = shifted - {1'b0, v_q};
      q_bit   = ~trial[W];

      state_d = state_q;
      dq_d    = dq_q;
      v_d     = v_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dz_d    = dz_q;

      unique case (state_q)
         StIdle, StFin: begin
            state_d = StIdle;
            if (START) begin
               if (DIVISOR != '0) begin
                  dq_d    = DIVIDEND;
                  v_d     = DIVISOR;
                  p_d     = '0;
                  cnt_d   = CW'(W);
                  state_d = StRun;
               end else begin
                  quo_d   = '1;
                  rem_d   = DIVIDEND;
                  dz_d    = 1'b1;
                  state_d = StFin;
               end
            end
         end
         StRun: begin
            p_d   = q_bit ? trial[W-1:0] : shifted[W-1:0];
            dq_d  = {dq_q[W-2:0], q_bit};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               quo_d   = dq_d;
               rem_d   = p_d;
               dz_d    = 1'b0;
               state_d = StFin;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge C) begin
      if (!RN) begin
         state_q <= StIdle;
         dq_q    <= '0;
         v_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dq_q    <= dq_d;
         v_q     <= v_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
      end
   end

   assign BUSY = (state_q == StRun);
   assign DONE = (state_q == StFin);
   assign QUO  = quo_q;
   assign REM  = rem_q;
   assign DZ   = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: W=8 vector table, hand-built multi-cycle sequences,
// random operands against a plain-arithmetic model, and an exhaustive W=4 sweep.
module tb_seq_divider;

   logic       clk = 1'b0;
   logic       rn;
   logic       start8;
   logic [7:0] dvd8, dvs8, quo8, rem8;
   logic       busy8, done8, dz8;
   logic       start4;
   logic [3:0] dvd4, dvs4, quo4, rem4;
   logic       busy4, done4, dz4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_divider #(.W(8)) dut8 (
      .C(clk), .RN(rn), .START(start8), .DIVIDEND(dvd8), .DIVISOR(dvs8),
      .BUSY(busy8), .DONE(done8), .QUO(quo8), .REM(rem8), .DZ(dz8)
   );

   seq_divider #(.W(4)) dut4 (
      .C(clk), .RN(rn), .START(start4), .DIVIDEND(dvd4), .DIVISOR(dvs4),
      .BUSY(busy4), .DONE(done4), .QUO(quo4), .REM(rem4), .DZ(dz4)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts a W=8 division in the current cycle and follows it to DONE.
   // glitch: cycle in which a 1/1 START is pulsed while busy (0 = none).
   // hold: the previous result must stay visible while busy.
   task automatic run8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic edz,
                       input int glitch, input logic hold,
                       input logic [7:0] hq, input logic [7:0] hr, input string nm);
      int   cyc;
      logic seen;
      start8 = 1'b1;
      dvd8   = a;
      dvs8   = b;
      step();
      start8 = 1'b0;
      dvd8   = 8'($urandom);
      dvs8   = 8'($urandom);
      cyc    = 1;
      seen   = 1'b0;
      while (cyc < 40 && !seen) begin
         if (done8) begin
            seen = 1'b1;
         end else begin
            chk($sformatf("%s busy c%0d", nm, cyc), {31'd0, busy8}, 32'd1);
            if (hold) begin
               chk($sformatf("%s held quo", nm), {24'd0, quo8}, {24'd0, hq});
               chk($sformatf("%s held rem", nm), {24'd0, rem8}, {24'd0, hr});
            end
            if (cyc == glitch) begin
               start8 = 1'b1;
               dvd8   = 8'd1;
               dvs8   = 8'd1;
            end else begin
               start8 = 1'b0;
            end
            step();
            cyc++;
         end
      end
      start8 = 1'b0;
      chk($sformatf("%s done seen", nm), {31'd0, seen}, 32'd1);
      chk($sformatf("%s latency", nm), cyc, edz ? 32'd1 : 32'd9);
      chk($sformatf("%s busy at done", nm), {31'd0, busy8}, 32'd0);
      chk($sformatf("%s quo", nm), {24'd0, quo8}, {24'd0, eq});
      chk($sformatf("%s rem", nm), {24'd0, rem8}, {24'd0, er});
      chk($sformatf("%s dz", nm), {31'd0, dz8}, {31'd0, edz});
   endtask

   task automatic run4(input logic [3:0] a, input logic [3:0] b);
      int   cyc;
      logic seen;
      int   recon;
      start4 = 1'b1;
      dvd4   = a;
      dvs4   = b;
      step();
      start4 = 1'b0;
      cyc    = 1;
      seen   = 1'b0;
      while (cyc < 20 && !seen) begin
         if (done4) seen = 1'b1;
         else begin
            step();
            cyc++;
         end
      end
      chk($sformatf("w4 %0d/%0d done", a, b), {31'd0, seen}, 32'd1);
      if (b == 4'd0) begin
         chk($sformatf("w4 %0d/0 dz", a), {31'd0, dz4}, 32'd1);
         chk($sformatf("w4 %0d/0 quo", a), {28'd0, quo4}, 32'hf);
         chk($sformatf("w4 %0d/0 rem", a), {28'd0, rem4}, {28'd0, a});
      end else begin
         recon = int'(quo4) * int'(b) + int'(rem4);
         chk($sformatf("w4 %0d/%0d identity", a, b), recon, {28'd0, a});
         chk($sformatf("w4 %0d/%0d rem<div", a, b), {31'd0, rem4 < b}, 32'd1);
         chk($sformatf("w4 %0d/%0d dz", a, b), {31'd0, dz4}, 32'd0);
         chk($sformatf("w4 %0d/%0d quo", a, b), {28'd0, quo4}, {28'd0, a / b});
      end
      step();
   endtask

   initial begin
      vec_t vecs[10];
      int   done_cnt;
      logic [7:0] ra, rb, mq, mr;

      vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
      vecs[1] = '{8'd5,   8'd0,   8'hff,  8'd5,  1'b1};
      vecs[2] = '{8'd6,   8'd3,   8'd2,   8'd0,  1'b0};
      vecs[3] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
      vecs[4] = '{8'd3,   8'd200, 8'd0,   8'd3,  1'b0};
      vecs[5] = '{8'd200, 8'd9,   8'd22,  8'd2,  1'b0};
      vecs[6] = '{8'd0,   8'd13,  8'd0,   8'd0,  1'b0};
      vecs[7] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
      vecs[8] = '{8'd128, 8'd3,   8'd42,  8'd2,  1'b0};
      vecs[9] = '{8'd254, 8'd16,  8'd15,  8'd14, 1'b0};

      rn = 1'b0; start8 = 1'b0; dvd8 = 8'd0; dvs8 = 8'd0;
      start4 = 1'b0; dvd4 = 4'd0; dvs4 = 4'd0;
      step();
      step();
      chk("reset busy", {31'd0, busy8}, 32'd0);
      chk("reset done", {31'd0, done8}, 32'd0);
      chk("reset quo", {24'd0, quo8}, 32'd0);
      chk("reset rem", {24'd0, rem8}, 32'd0);
      chk("reset dz", {31'd0, dz8}, 32'd0);
      rn = 1'b1;
      step();

      for (int i = 0; i < 10; i++) begin
         run8(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, 0, 1'b0, 8'd0, 8'd0,
              $sformatf("vec%0d", i));
         step();
      end

      // Back-to-back: second START issued in the DONE cycle of the first.
      run8(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 0, 1'b0, 8'd0, 8'd0, "b2b first");
      run8(8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 0, 1'b1, 8'd255, 8'd0, "b2b second");
      step();

      run8(8'd5, 8'd0, 8'hff, 8'd5, 1'b1, 0, 1'b0, 8'd0, 8'd0, "dz");
      run8(8'd6, 8'd3, 8'd2, 8'd0, 1'b0, 0, 1'b1, 8'hff, 8'd5, "after dz");
      step();

      run8(8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 4, 1'b0, 8'd0, 8'd0, "ignored start");
      step();

      // Reset in cycle 5 of 77/5 abandons it.
      start8 = 1'b1; dvd8 = 8'd77; dvs8 = 8'd5;
      step();
      start8 = 1'b0;
      for (int i = 1; i < 5; i++) step();
      rn = 1'b0;
      step();
      rn = 1'b1;
      chk("abort busy", {31'd0, busy8}, 32'd0);
      chk("abort done", {31'd0, done8}, 32'd0);
      chk("abort quo", {24'd0, quo8}, 32'd0);
      chk("abort rem", {24'd0, rem8}, 32'd0);
      chk("abort dz", {31'd0, dz8}, 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 14; i++) begin
         if (done8) done_cnt++;
         step();
      end
      chk("abort no done", done_cnt, 32'd0);
      run8(8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 0, 1'b0, 8'd0, 8'd0, "fresh 77/5");
      step();

      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         rb = (i % 8 == 0) ? 8'd0 : 8'($urandom);
         mq = (rb == 8'd0) ? 8'hff : ra / rb;
         mr = (rb == 8'd0) ? ra : ra % rb;
         run8(ra, rb, mq, mr, rb == 8'd0, 0, 1'b0, 8'd0, 8'd0, $sformatf("rnd%0d", i));
         if ($urandom_range(1, 0) == 1) step();
      end

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run4(4'(a), 4'(b));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
